// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Start/fetch, memory read and instruction-register signals
//            exchanged between the fetch sequencer and its environment.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] pc_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  ir_ld_o;
    logic [DATA_WIDTH-1:0] ir_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  fault_o;
    logic [1:0]            fault_code_o;

    // Environment side: issues fetches, models memory, observes the register load.
    modport master (
        output start_i, pc_i, mem_ack_i, mem_data_i,
        input  mem_req_o, mem_addr_o, ir_ld_o, ir_data_o,
        input  busy_o, done_o, fault_o, fault_code_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, pc_i, mem_ack_i, mem_data_i,
        output mem_req_o, mem_addr_o, ir_ld_o, ir_data_o,
        output busy_o, done_o, fault_o, fault_code_o
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Multi-cycle instruction fetch: word read, latch, one-cycle
//            active-low IR load strobe, then done/fault pulse.
//            Optional macro FETCH_TIMEOUT_EN adds a REQ-state timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire               clk_i,
    input  wire               reset_ni,
    fetch_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] c_CODE_NONE      = 2'b00;
    localparam logic [1:0] c_CODE_MISALIGN  = 2'b01;
    localparam logic [1:0] c_CODE_TIMEOUT   = 2'b10;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic [DATA_WIDTH-1:0] r_data,  w_data_next;
    logic [1:0]            r_code,  w_code_next;
    logic                  r_req, r_ld_n, r_busy, r_done, r_fault;
    logic                  w_timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Counts REQ cycles without ack; zero whenever outside REQ, so it is
    // cleared on every REQ entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (r_state != S_REQ) begin
            r_cnt <= '0;
        end else if (!bus.mem_ack_i) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_code_next  = r_code;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (bus.pc_i[1:0] == 2'b00) begin
                        w_addr_next  = bus.pc_i;
                        w_code_next  = c_CODE_NONE;
                        w_state_next = S_REQ;
                    end else begin
                        w_code_next  = c_CODE_MISALIGN;
                        w_state_next = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                // An ack on the limit cycle still completes normally.
                if (bus.mem_ack_i) begin
                    w_data_next  = bus.mem_data_i;
                    w_state_next = S_LOAD;
                end else if (w_timeout) begin
                    w_code_next  = c_CODE_TIMEOUT;
                    w_state_next = S_FAULT;
                end
            end
            S_LOAD:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            S_FAULT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the IR strobe is glitch-free.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_code  <= c_CODE_NONE;
            r_req   <= 1'b0;
            r_ld_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_code  <= w_code_next;
            r_req   <= (w_state_next == S_REQ);
            r_ld_n  <= (w_state_next != S_LOAD);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
            r_fault <= (w_state_next == S_FAULT);
        end
    end

    assign bus.mem_req_o    = r_req;
    assign bus.mem_addr_o   = r_addr;
    assign bus.ir_ld_o      = r_ld_n;
    assign bus.ir_data_o    = r_data;
    assign bus.busy_o       = r_busy;
    assign bus.done_o       = r_done;
    assign bus.fault_o      = r_fault;
    assign bus.fault_code_o = r_code;

endmodule

`default_nettype wire
